// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, default timing constants
// and common host-to-keyboard command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    START   = 3'd2,
    TX      = 3'd3,
    ACK     = 3'd4,
    RELEASE = 3'd5
  } tx_state_t;

  localparam int DEF_INHIBIT_CYCLES = 6000;
  localparam int DEF_START_CYCLES   = 1000;
  localparam int DEF_TIMEOUT_CYCLES = 750000;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins plus a glitch-free
// falling-edge strobe on the synchronized clock. Shared with the receive path.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic clk_in,
  input  logic dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic [1:0] clk_meta;
  logic [1:0] dat_meta;
  logic       clk_prev;

  // Idle bus level is high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta <= 2'b11;
      dat_meta <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_meta <= {clk_meta[0], clk_in};
      dat_meta <= {dat_meta[0], dat_in};
      clk_prev <= clk_meta[1];
    end
  end

  assign clk_sync = clk_meta[1];
  assign dat_sync = dat_meta[1];
  assign clk_fall = clk_prev & ~clk_meta[1];

endmodule

// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain lines via low-enables.
// Optional watchdog from CLK release to completion: define PS2_TX_TIMEOUT_EN.
module ps2_command_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int START_CYCLES   = DEF_START_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_send,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       cmd_busy,
  output logic       cmd_done,
  output logic       cmd_error
);

  localparam int MAX_IS     = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int MAX_CYCLES = (MAX_IS > TIMEOUT_CYCLES) ? MAX_IS : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_CYCLES - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [8:0]       shreg;
  logic             ack_ok;
  logic             clk_sync;
  logic             dat_sync;
  logic             clk_fall;
  logic             timeout;

  ps2_line_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .clk_in   (ps2_clk_in),
    .dat_in   (ps2_dat_in),
    .clk_sync (clk_sync),
    .dat_sync (dat_sync),
    .clk_fall (clk_fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wd_cnt;

  // Watchdog is armed while START hands over the clock and runs until RELEASE exits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == START) begin
      wd_cnt <= '0;
    end else if (state == TX || state == ACK || state == RELEASE) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout = (state == TX || state == ACK || state == RELEASE) && (wd_cnt == TIMEOUT_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      ack_ok     <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      cmd_busy   <= 1'b0;
      cmd_done   <= 1'b0;
      cmd_error  <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      if (timeout) begin
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        cmd_done   <= 1'b1;
        cmd_error  <= 1'b1;
        cmd_busy   <= 1'b0;
        state      <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (cmd_send) begin
              shreg      <= {odd_parity(cmd_data), cmd_data};
              cmd_error  <= 1'b0;
              cmd_busy   <= 1'b1;
              ps2_clk_oe <= 1'b1;
              cnt        <= '0;
              state      <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (cnt == INHIBIT_LAST) begin
              cnt        <= '0;
              ps2_dat_oe <= 1'b1;
              state      <= START;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          START: begin
            if (cnt == START_LAST) begin
              cnt        <= '0;
              ps2_clk_oe <= 1'b0;
              bit_idx    <= '0;
              state      <= TX;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          // Data and parity shift out LSB first; the tenth edge releases DAT as the stop bit.
          TX: begin
            if (clk_fall) begin
              if (bit_idx == 4'd9) begin
                ps2_dat_oe <= 1'b0;
                state      <= ACK;
              end else begin
                ps2_dat_oe <= ~shreg[0];
                shreg      <= shreg >> 1;
                bit_idx    <= bit_idx + 1'b1;
              end
            end
          end
          ACK: begin
            if (clk_fall) begin
              ack_ok <= ~dat_sync;
              state  <= RELEASE;
            end
          end
          RELEASE: begin
            if (clk_sync && dat_sync) begin
              cmd_done  <= 1'b1;
              cmd_error <= ~ack_ok;
              cmd_busy  <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_command_tx.sv
// Testbench for ps2_command_tx with a behavioural PS/2 keyboard model.
// Define PS2_TX_TIMEOUT_EN to exercise the watchdog build.
module tb_ps2_command_tx;
  import ps2_pkg::*;

  localparam int INH  = 50;
  localparam int STA  = 10;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cmd_data = '0;
  logic       cmd_send = 1'b0;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       cmd_busy;
  logic       cmd_done;
  logic       cmd_error;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  int checks = 0;
  int passed = 0;
  int done_count = 0;
  logic err_at_done = 1'b0;

  typedef struct {
    logic [7:0] cmd;
    bit         ack;
    bit         par;
    bit         err;
  } vec_t;

  vec_t vecs[8];

  ps2_command_tx #(
    .INHIBIT_CYCLES (INH),
    .START_CYCLES   (STA),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_data   (cmd_data),
    .cmd_send   (cmd_send),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .cmd_busy   (cmd_busy),
    .cmd_done   (cmd_done),
    .cmd_error  (cmd_error)
  );

  always #5 clk = ~clk;

  // Open-drain wired-AND of host and device pull-downs.
  assign ps2_clk_in = ~ps2_clk_oe & ~dev_clk_low;
  assign ps2_dat_in = ~ps2_dat_oe & ~dev_dat_low;

  always @(negedge clk) begin
    if (cmd_done) begin
      done_count++;
      err_at_done = cmd_error;
    end
  end

  // Expected frame seen by the device: data LSB first, odd parity, stop = 1.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_pulse(input logic [7:0] b);
    cmd_data = b;
    cmd_send = 1'b1;
    @(negedge clk);
    cmd_send = 1'b0;
  endtask

  task automatic device_run(input int n_pulses, input bit do_ack,
                            output logic [9:0] frame, output bit ok);
    int waited;
    waited = 0;
    frame  = '0;
    while (!(ps2_clk_in && !ps2_dat_in) && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    ok = (waited < 5000);
    if (ok) begin
      repeat (HALF) @(negedge clk);
      for (int k = 0; k < n_pulses && k < 10; k++) begin
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        frame[k] = ps2_dat_in;
        repeat (HALF) @(negedge clk);
      end
      if (n_pulses >= 11) begin
        if (do_ack) dev_dat_low = 1'b1;
        repeat (HALF / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        dev_dat_low = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_count == d0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [9:0] frame;
    bit ok;
    int d0;
    d0 = done_count;
    send_pulse(v.cmd);
    checkOutput("busy_on_accept", cmd_busy, 1);
    checkOutput("error_cleared", cmd_error, 0);
    device_run(11, v.ack, frame, ok);
    checkOutput("host_release", ok, 1);
    wait_done(d0);
    checkOutput("frame", frame, {1'b1, v.par, v.cmd});
    checkOutput("done_pulses", done_count - d0, 1);
    checkOutput("error_at_done", err_at_done, v.err);
    checkOutput("error_hold", cmd_error, v.err);
    checkOutput("busy_after", cmd_busy, 0);
  endtask

  initial begin
    logic [9:0] frame;
    bit ok;
    int d0;
    int n;
    logic [7:0] b;

    vecs[0] = '{cmd: CMD_ENABLE,  ack: 1'b1, par: 1'b0, err: 1'b0};
    vecs[1] = '{cmd: CMD_SET_LED, ack: 1'b1, par: 1'b1, err: 1'b0};
    vecs[2] = '{cmd: CMD_RESET,   ack: 1'b1, par: 1'b1, err: 1'b0};
    vecs[3] = '{cmd: 8'hAA,       ack: 1'b0, par: 1'b1, err: 1'b1};
    vecs[4] = '{cmd: 8'h00,       ack: 1'b1, par: 1'b1, err: 1'b0};
    for (int i = 5; i < 8; i++) begin
      b = 8'($urandom);
      frame = model_frame(b);
      vecs[i].cmd = b;
      vecs[i].ack = 1'($urandom % 2);
      vecs[i].par = frame[8];
      vecs[i].err = ~vecs[i].ack;
    end

    repeat (4) @(negedge clk);
    checkOutput("reset_outputs", {ps2_clk_oe, ps2_dat_oe, cmd_busy, cmd_done, cmd_error}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // cmd_send and new data during TX must be ignored.
    d0 = done_count;
    send_pulse(8'h3C);
    fork
      device_run(11, 1'b1, frame, ok);
      begin
        repeat (INH + STA + 60) @(negedge clk);
        send_pulse(8'h00);
      end
    join
    wait_done(d0);
    checkOutput("latched_frame", frame, model_frame(8'h3C));
    repeat (300) @(negedge clk);
    checkOutput("no_queued_done", done_count - d0, 1);
    checkOutput("no_queued_busy", cmd_busy, 0);

    // Asynchronous reset in the middle of a byte.
    d0 = done_count;
    send_pulse(8'h52);
    device_run(4, 1'b0, frame, ok);
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_dat_oe", ps2_dat_oe, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_lines", {ps2_clk_oe, ps2_dat_oe}, 0);
    checkOutput("async_reset_busy", cmd_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("reset_no_done", done_count - d0, 0);
    applyStimulus(vecs[0]);

    // Silent device after CLK release.
    d0 = done_count;
    send_pulse(8'h12);
    n = 0;
    while (ps2_clk_oe && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("clk_released", ps2_clk_oe, 0);
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (!cmd_done && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("timeout_cycles", n, TMO);
    checkOutput("timeout_error", cmd_error, 1);
    checkOutput("timeout_lines", {ps2_clk_oe, ps2_dat_oe, cmd_busy}, 0);
`else
    n = 0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      if (cmd_busy) n++;
    end
    checkOutput("stuck_busy_cycles", n, 10000);
    checkOutput("stuck_no_done", done_count - d0, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
